// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the ALU operation codes and the control bundle
// that travels with an instruction from decode into execute.
// The bundle's alu_op field is ALU_OP_W bits wide. Any stage that carries it
// must be built with OPCODE_LENGTH equal to ALU_OP_W.
package pipe_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1011;
    localparam logic [ALU_OP_W-1:0] ALU_BGE  = 4'b1100;
    localparam logic [ALU_OP_W-1:0] ALU_BGEU = 4'b1101;
    localparam logic [ALU_OP_W-1:0] ALU_BNE  = 4'b1110;

    typedef struct packed {
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic                memtoreg;
        logic                branch;
        logic                alusrc;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{default: '0};

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one source register.
// Ports:
//   rs_idx_i        register index of the operand held in EX
//   rs_data_i       register-file value captured with that operand
//   mem_regwrite_i, mem_rd_i, mem_result_i   result about to leave MEM
//   wb_regwrite_i,  wb_rd_i,  wb_result_i    result being written back
//   fwd_data_o      newest value of the operand
// MEM is the younger producer, so it wins when both stages match.
// Register x0 is hard-wired, so index 0 never forwards.
module fwd_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] rs_idx_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    input  logic                  mem_regwrite_i,
    input  logic [ADDR_WIDTH-1:0] mem_rd_i,
    input  logic [DATA_WIDTH-1:0] mem_result_i,
    input  logic                  wb_regwrite_i,
    input  logic [ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0] wb_result_i,
    output logic [DATA_WIDTH-1:0] fwd_data_o
);

    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        fwd_data_o = rs_data_i;
        if (rs_idx_i != '0) begin
            if (mem_regwrite_i && (mem_rd_i == rs_idx_i)) begin
                fwd_data_o = mem_result_i;
            end else if (wb_regwrite_i && (wb_rd_i == rs_idx_i)) begin
                fwd_data_o = wb_result_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_*                        decoded instruction (valid, control, indices, data)
//   stall, flush                hazard-unit hold / bubble requests (flush wins)
//   mem_*, wb_*                 forwarding sources from later stages
//   ex_*                        registered valid, control and pass-through fields
//   alu_srca/srcb/operation     ALU operands and operation
//   ex_store_data               forwarded rs2 for stores
//   load_use                    load in EX feeds the instruction in decode
// A stall holds the instruction but keeps refreshing its operands with the
// forwarded values. A producer that retires from WB during the stall is
// therefore still seen once the stall ends.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int ADDR_WIDTH    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     id_memwrite,
    input  logic                     id_memtoreg,
    input  logic                     id_branch,
    input  logic                     id_alusrc,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic [ADDR_WIDTH-1:0]    id_rs1,
    input  logic [ADDR_WIDTH-1:0]    id_rs2,
    input  logic [ADDR_WIDTH-1:0]    id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     mem_regwrite,
    input  logic [ADDR_WIDTH-1:0]    mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic                     wb_regwrite,
    input  logic [ADDR_WIDTH-1:0]    wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic                     ex_valid,
    output logic                     ex_regwrite,
    output logic                     ex_memread,
    output logic                     ex_memwrite,
    output logic                     ex_memtoreg,
    output logic                     ex_branch,
    output logic [ADDR_WIDTH-1:0]    ex_rd,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [DATA_WIDTH-1:0]    ex_imm,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     load_use
);

    logic                  valid_q,    valid_d;
    ctrl_t                 ctrl_q,     ctrl_d;
    logic [ADDR_WIDTH-1:0] rs1_q,      rs1_d;
    logic [ADDR_WIDTH-1:0] rs2_q,      rs2_d;
    logic [ADDR_WIDTH-1:0] rd_q,       rd_d;
    logic [DATA_WIDTH-1:0] pc_q,       pc_d;
    logic [DATA_WIDTH-1:0] imm_q,      imm_d;
    logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;

    logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;
    ctrl_t                 id_ctrl;

    fwd_unit #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs1 (
        .rs_idx_i       (rs1_q),
        .rs_data_i      (rs1_data_q),
        .mem_regwrite_i (mem_regwrite),
        .mem_rd_i       (mem_rd),
        .mem_result_i   (mem_result),
        .wb_regwrite_i  (wb_regwrite),
        .wb_rd_i        (wb_rd),
        .wb_result_i    (wb_result),
        .fwd_data_o     (fwd_rs1)
    );

    fwd_unit #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs2 (
        .rs_idx_i       (rs2_q),
        .rs_data_i      (rs2_data_q),
        .mem_regwrite_i (mem_regwrite),
        .mem_rd_i       (mem_rd),
        .mem_result_i   (mem_result),
        .wb_regwrite_i  (wb_regwrite),
        .wb_rd_i        (wb_rd),
        .wb_result_i    (wb_result),
        .fwd_data_o     (fwd_rs2)
    );

    // An invalid decode slot enters EX as a bubble, including the ALU code.
    always_comb begin
        id_ctrl = CTRL_NOP;
        if (id_valid) begin
            id_ctrl.regwrite = id_regwrite;
            id_ctrl.memread  = id_memread;
            id_ctrl.memwrite = id_memwrite;
            id_ctrl.memtoreg = id_memtoreg;
            id_ctrl.branch   = id_branch;
            id_ctrl.alusrc   = id_alusrc;
            id_ctrl.alu_op   = id_alu_op;
        end
    end

    // Priority: flush > stall > normal load.
    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (flush) begin
            valid_d    = 1'b0;
            ctrl_d     = CTRL_NOP;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            pc_d       = '0;
            imm_d      = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
        end else if (stall) begin
            rs1_data_d = fwd_rs1;
            rs2_data_d = fwd_rs2;
        end else begin
            valid_d    = id_valid;
            ctrl_d     = id_ctrl;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            pc_d       = id_pc;
            imm_d      = id_imm;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= CTRL_NOP;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_regwrite   = ctrl_q.regwrite;
    assign ex_memread    = ctrl_q.memread;
    assign ex_memwrite   = ctrl_q.memwrite;
    assign ex_memtoreg   = ctrl_q.memtoreg;
    assign ex_branch     = ctrl_q.branch;
    assign ex_rd         = rd_q;
    assign ex_pc         = pc_q;
    assign ex_imm        = imm_q;
    assign alu_operation = ctrl_q.alu_op;
    assign alu_srca      = fwd_rs1;
    assign alu_srcb      = ctrl_q.alusrc ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

    assign load_use = valid_q && ctrl_q.memread && (rd_q != '0) && id_valid &&
                      ((rd_q == id_rs1) || (rd_q == id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage. A behavioural model holds the
// instruction currently in EX and derives every expected output from it plus
// the live forwarding and decode inputs.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        id_branch, id_alusrc;
    logic [3:0]  id_alu_op;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        stall, flush;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc, ex_imm, alu_srca, alu_srcb, ex_store_data;
    logic [3:0]  alu_operation;
    logic        load_use;

    int n_vec = 0;
    int n_err = 0;

    // Model of the instruction sitting in EX.
    logic        m_valid, m_regwrite, m_memread, m_memwrite, m_memtoreg, m_branch, m_alusrc;
    logic [3:0]  m_alu_op;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_pc, m_imm, m_d1, m_d2;

    logic [3:0] op_codes [13] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
                                  4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                                  4'b1100, 4'b1101, 4'b1110};

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_branch(id_branch),
        .id_alusrc(id_alusrc), .id_alu_op(id_alu_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .stall(stall), .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
        .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_operation(alu_operation),
        .ex_store_data(ex_store_data), .load_use(load_use)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Newest value of a register as seen from EX.
    function automatic logic [31:0] fwd_ref(input logic [4:0] idx, input logic [31:0] regval);
        if (idx == 0)                        return regval;
        if (mem_regwrite && mem_rd == idx)   return mem_result;
        if (wb_regwrite && wb_rd == idx)     return wb_result;
        return regval;
    endfunction

    task automatic model_reset();
        {m_valid, m_regwrite, m_memread, m_memwrite, m_memtoreg, m_branch, m_alusrc} = '0;
        m_alu_op = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_pc = '0; m_imm = '0; m_d1 = '0; m_d2 = '0;
    endtask

    task automatic clear_inputs();
        {id_valid, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch, id_alusrc} = '0;
        id_alu_op = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_pc = '0;
        stall = 1'b0; flush = 1'b0;
        mem_regwrite = 1'b0; mem_rd = '0; mem_result = '0;
        wb_regwrite = 1'b0; wb_rd = '0; wb_result = '0;
    endtask

    task automatic check_all();
        logic [31:0] b;
        logic        lu;
        b  = fwd_ref(m_rs2, m_d2);
        lu = m_valid && m_memread && (m_rd != 0) && id_valid &&
             ((m_rd == id_rs1) || (m_rd == id_rs2));
        check("ctrl", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch},
                      {m_valid, m_regwrite, m_memread, m_memwrite, m_memtoreg, m_branch});
        check("ex_rd", ex_rd, m_rd);
        check("ex_pc", ex_pc, m_pc);
        check("ex_imm", ex_imm, m_imm);
        check("alu_op", alu_operation, m_alu_op);
        check("srca", alu_srca, fwd_ref(m_rs1, m_d1));
        check("srcb", alu_srcb, m_alusrc ? m_imm : b);
        check("store", ex_store_data, b);
        check("load_use", load_use, lu);
    endtask

    // Inputs are set just after a falling edge; check, then advance the model
    // across the next rising edge, and return at the following falling edge.
    task automatic step();
        logic [31:0] n1, n2;
        #1;
        check_all();
        n1 = fwd_ref(m_rs1, m_d1);
        n2 = fwd_ref(m_rs2, m_d2);
        @(posedge clk);
        if (flush) begin
            model_reset();
        end else if (stall) begin
            m_d1 = n1;
            m_d2 = n2;
        end else begin
            m_valid    = id_valid;
            m_regwrite = id_valid & id_regwrite;
            m_memread  = id_valid & id_memread;
            m_memwrite = id_valid & id_memwrite;
            m_memtoreg = id_valid & id_memtoreg;
            m_branch   = id_valid & id_branch;
            m_alusrc   = id_valid & id_alusrc;
            m_alu_op   = id_valid ? id_alu_op : 4'b0000;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_pc = id_pc; m_imm = id_imm; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
        end
        @(negedge clk);
    endtask

    // Reset pulse between edges; returns before the next rising edge.
    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        check("rst_valid", ex_valid, 1'b0);
        #1 rst_n = 1'b1;
    endtask

    task automatic randomize_inputs();
        id_valid    = ($urandom_range(0, 3) != 0);
        id_regwrite = $urandom_range(0, 1);
        id_memread  = $urandom_range(0, 1);
        id_memwrite = $urandom_range(0, 1);
        id_memtoreg = $urandom_range(0, 1);
        id_branch   = $urandom_range(0, 1);
        id_alusrc   = $urandom_range(0, 1);
        id_alu_op   = op_codes[$urandom_range(0, 12)];
        id_rs1 = 5'($urandom_range(0, 3));
        id_rs2 = 5'($urandom_range(0, 3));
        id_rd  = 5'($urandom_range(0, 3));
        id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_imm = $urandom; id_pc = $urandom;
        stall = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 7) == 0);
        mem_regwrite = $urandom_range(0, 1);
        wb_regwrite  = $urandom_range(0, 1);
        mem_rd = 5'($urandom_range(0, 3));
        wb_rd  = 5'($urandom_range(0, 3));
        mem_result = $urandom; wb_result = $urandom;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Basic load: operands and operation appear one cycle later.
        id_valid = 1; id_regwrite = 1; id_alu_op = 4'b0010;
        id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_rs1_data = 5; id_rs2_data = 7;
        step();
        clear_inputs();
        #1;
        check("basic_srca", alu_srca, 32'd5);
        check("basic_srcb", alu_srcb, 32'd7);
        check("basic_op", alu_operation, 32'h2);
        step();

        // MEM forward beats WB.
        id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h11;
        step();
        clear_inputs();
        mem_regwrite = 1; mem_rd = 3; mem_result = 32'hAA;
        wb_regwrite = 1;  wb_rd = 3;  wb_result = 32'hBB;
        #1 check("mem_prio", alu_srca, 32'hAA);
        step();

        // x0 never forwards.
        clear_inputs();
        id_valid = 1; id_rs1 = 0; id_rs1_data = 0;
        step();
        clear_inputs();
        mem_regwrite = 1; mem_rd = 0; mem_result = 32'hFF;
        #1 check("x0_srca", alu_srca, 32'h0);
        step();

        // Load-use, stall, and WB capture during the stall.
        clear_inputs();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd = 4;
        id_rs1 = 1; id_rs2 = 4; id_rs2_data = 32'h99; id_pc = 32'h40;
        step();
        clear_inputs();
        id_valid = 1; id_rs2 = 4; stall = 1;
        wb_regwrite = 1; wb_rd = 4; wb_result = 32'h10;
        #1 check("load_use", load_use, 1'b1);
        step();
        clear_inputs();
        #1;
        check("stall_rd", ex_rd, 32'd4);
        check("stall_memread", ex_memread, 1'b1);
        check("stall_pc", ex_pc, 32'h40);
        check("stall_srcb", alu_srcb, 32'h10);
        step();

        // Flush beats stall.
        id_valid = 1; id_regwrite = 1; id_branch = 1; id_alu_op = 4'b0110;
        step();
        stall = 1; flush = 1;
        step();
        #1;
        check("flush_valid", ex_valid, 1'b0);
        check("flush_ctrl", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch}, 0);
        check("flush_op", alu_operation, 0);

        // Asynchronous reset with a valid instruction in EX; reset overrides
        // stall/flush and the next edge is a normal load.
        clear_inputs();
        id_valid = 1; id_regwrite = 1; id_memwrite = 1; id_pc = 32'h1234; id_alu_op = 4'b1011;
        step();
        stall = 1; flush = 1;
        pulse_reset();
        clear_inputs();
        id_valid = 1; id_memtoreg = 1; id_rd = 7; id_pc = 32'h88;
        step();
        #1 check("post_rst_pc", ex_pc, 32'h88);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            if ($urandom_range(0, 39) == 0) pulse_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
